lc4_alu_mc: RTL and testbench
=============================

LC4_ALU_MC -- requirements
Module: lc4_alu_mc

Interface
REQ-001 Parameter WORD_SIZE, default 16, datapath width in bits; legal values 16 and 32.
REQ-002 Parameter MUL_BITS, default 1, multiplier bits retired per cycle; legal values 1, 2 and 4, and it SHALL divide WORD_SIZE.
REQ-003 Port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port i_valid  input  1  request present on i_insn/i_pc/i_r1data/i_r2data.
REQ-006 Port o_ready  output  1  block can accept a request this cycle.
REQ-007 Port i_insn  input  16  LC4 instruction word.
REQ-008 Port i_pc  input  16  PC of the instruction.
REQ-009 Port i_r1data, i_r2data  input  WORD_SIZE  source operands.
REQ-010 Port i_flush  input  1  abort in-flight operation and discard any held result.
REQ-011 Port o_valid  output  1  o_result is valid.
REQ-012 Port i_ready  input  1  consumer accepts o_result this cycle.
REQ-013 Port o_result  output  WORD_SIZE  registered result.
REQ-014 Port o_busy  output  1  high in MUL or DIV state.

Function
REQ-015 A request is accepted on a cycle with i_valid && o_ready; operands and insn are captured internally and are not sampled again.
REQ-016 o_ready SHALL be high in IDLE, and high in DONE when i_ready is high (back-to-back issue); otherwise low.
REQ-017 Single-cycle ops are all LC4 ALU ops other than MUL, DIV and MOD. For these, o_valid SHALL rise the cycle after acceptance (latency 1) with the ISA-defined result.
REQ-018 Single-cycle op results are: arithmetic, logical, shift, CMP/CMPU/CMPI/CMPIU (-1/0/+1), CONST, HICONST, LDR/STR address, BR/JMP target, JSR/JSRR/JMPR/RTI/TRAP target.
REQ-019 MUL (opcode 0001, insn[5:3]=001) SHALL be iterative shift-add, MUL_BITS bits per cycle. Result is the low WORD_SIZE bits of the product; o_valid SHALL rise WORD_SIZE/MUL_BITS+1 cycles after acceptance.
REQ-020 DIV (insn[5:3]=011) and MOD (opcode 1010, insn[5:4]=11) SHALL be unsigned restoring division, 1 quotient bit per cycle. DIV returns the quotient, MOD the remainder; o_valid SHALL rise WORD_SIZE+1 cycles after acceptance.
REQ-021 A zero divisor SHALL produce result 0 for both DIV and MOD, with the same latency as a nonzero divisor.
REQ-022 FSM states: IDLE, MUL, DIV, DONE.
REQ-023 IDLE transitions on acceptance: single-cycle op -> DONE; MUL -> MUL; DIV/MOD -> DIV.
REQ-024 MUL and DIV SHALL go to DONE when the iteration counter reaches its final count.
REQ-025 DONE SHALL hold o_valid and o_result stable until i_ready. On i_ready it goes to IDLE, or straight to the next op's state if a new request is accepted in the same cycle.
REQ-026 i_flush SHALL take priority over all other events: next state IDLE, o_valid low, counter cleared. A request presented in the flush cycle SHALL NOT be accepted.
REQ-027 The iteration counter width is $clog2(WORD_SIZE)+1; it SHALL NOT wrap during an operation.
REQ-028 Arithmetic wraps modulo 2^WORD_SIZE. Immediates are sign- or zero-extended to WORD_SIZE per the ISA. PC-relative targets use the 16-bit PC zero-extended.

Reset
REQ-029 On i_rst_n low, asynchronously: state IDLE, o_valid 0, o_result 0, o_busy 0, counter 0, all operand registers 0.
REQ-030 o_ready SHALL be 1 while in reset-released IDLE.
REQ-031 Reset asserted mid-MUL/DIV SHALL abandon the operation with no result produced.

Structure
REQ-032 Shared package lc4_alu_pkg holds: the FSM state enum, the op-class enum (SINGLE, MUL, DIV, MOD), and opcode/subop localparams.
REQ-033 One sub-module, lc4_alu_iter, SHALL hold the shift-add multiplier and restoring divider datapath with start/done signals. Decode, the single-cycle datapath and the FSM stay in lc4_alu_mc.

Verification
REQ-034 ADD: r1=0x0005, r2=0x0003, i_ready=1 -> o_valid exactly 1 cycle after acceptance, o_result=0x0008.
REQ-035 MUL, WORD_SIZE=16, MUL_BITS=1: 0x0123*0x0045 -> o_result=0x4E6F at cycle 17 after acceptance. With MUL_BITS=4 the same result arrives at cycle 5.
REQ-036 DIV 0x0064/0x0007 -> 0x000E; MOD -> 0x0002; divisor 0 -> 0x0000 for both; each at cycle 17.
REQ-037 Backpressure: result ready with i_ready=0 for 5 cycles -> o_result stable, o_ready=0. Then i_ready=1 with i_valid=1 -> new op accepted that same cycle.
REQ-038 i_flush at cycle 8 of a DIV -> o_valid never rises for it, state IDLE next cycle. A following ADD completes normally.
REQ-039 i_rst_n low mid-MUL -> all outputs 0 immediately. After release, o_ready=1 and a CMP of 0xFFFF vs 0x0001 (signed) -> 0xFFFF.

Source files
------------

// File: rtl/lc4_alu_pkg.sv
// Shared definitions for the multi-cycle LC4 ALU.
// Holds the controller state encoding, the operation class produced by
// decode, LC4 opcode / sub-opcode constants and the decode helper that
// sorts an instruction into an operation class.
package lc4_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OPC_SINGLE = 2'd0,
        OPC_MUL    = 2'd1,
        OPC_DIV    = 2'd2,
        OPC_MOD    = 2'd3
    } op_class_t;

    localparam logic [3:0] OP_BR      = 4'b0000;
    localparam logic [3:0] OP_ARITH   = 4'b0001;
    localparam logic [3:0] OP_CMP     = 4'b0010;
    localparam logic [3:0] OP_JSR     = 4'b0100;
    localparam logic [3:0] OP_LOGIC   = 4'b0101;
    localparam logic [3:0] OP_LDR     = 4'b0110;
    localparam logic [3:0] OP_STR     = 4'b0111;
    localparam logic [3:0] OP_RTI     = 4'b1000;
    localparam logic [3:0] OP_CONST   = 4'b1001;
    localparam logic [3:0] OP_SHIFT   = 4'b1010;
    localparam logic [3:0] OP_JMP     = 4'b1100;
    localparam logic [3:0] OP_HICONST = 4'b1101;
    localparam logic [3:0] OP_TRAP    = 4'b1111;

    // insn[5:3] of arithmetic ops (insn[5]=1 is ADD immediate)
    localparam logic [2:0] ARITH_ADD = 3'b000;
    localparam logic [2:0] ARITH_MUL = 3'b001;
    localparam logic [2:0] ARITH_SUB = 3'b010;
    localparam logic [2:0] ARITH_DIV = 3'b011;

    // insn[5:3] of logical ops (insn[5]=1 is AND immediate)
    localparam logic [2:0] LOGIC_AND = 3'b000;
    localparam logic [2:0] LOGIC_NOT = 3'b001;
    localparam logic [2:0] LOGIC_OR  = 3'b010;
    localparam logic [2:0] LOGIC_XOR = 3'b011;

    // insn[8:7] of compares
    localparam logic [1:0] CMP_S  = 2'b00;
    localparam logic [1:0] CMP_U  = 2'b01;
    localparam logic [1:0] CMP_SI = 2'b10;
    localparam logic [1:0] CMP_UI = 2'b11;

    // insn[5:4] of shift / mod
    localparam logic [1:0] SHF_SLL = 2'b00;
    localparam logic [1:0] SHF_SRA = 2'b01;
    localparam logic [1:0] SHF_SRL = 2'b10;
    localparam logic [1:0] SHF_MOD = 2'b11;

    function automatic op_class_t decode_class(input logic [15:0] insn);
        op_class_t cls;
        cls = OPC_SINGLE;
        if (insn[15:12] == OP_ARITH && insn[5:3] == ARITH_MUL)
            cls = OPC_MUL;
        else if (insn[15:12] == OP_ARITH && insn[5:3] == ARITH_DIV)
            cls = OPC_DIV;
        else if (insn[15:12] == OP_SHIFT && insn[5:4] == SHF_MOD)
            cls = OPC_MOD;
        return cls;
    endfunction

endpackage

// File: rtl/lc4_alu_iter.sv
// Iterative datapath for the LC4 ALU: shift-add multiplier retiring
// MUL_BITS multiplier bits per cycle, and unsigned restoring divider
// retiring one quotient bit per cycle.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clear           abandon the operation in flight
//   start           capture a, b and op, begin iterating next cycle
//   op              OPC_MUL / OPC_DIV / OPC_MOD
//   a, b            multiplicand/dividend (a), multiplier/divisor (b)
//   done            high during the final iteration cycle
//   result          value of the operation, valid while done is high
module lc4_alu_iter
    import lc4_alu_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int MUL_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 start,
    input  op_class_t            op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result
);

    localparam int W  = WORD_SIZE;
    localparam int CW = $clog2(WORD_SIZE) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(WORD_SIZE / MUL_BITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WORD_SIZE - 1);

    logic          active;
    op_class_t     mode;
    logic [CW-1:0] cnt;
    // acc: product accumulator or partial remainder
    // opa: multiplier (shifts right) or dividend/quotient (shifts left)
    // opb: multiplicand (shifts left) or divisor
    logic [W-1:0]  acc;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;

    logic [W-1:0]  partial;
    logic [W-1:0]  mul_acc;
    logic [W:0]    shifted;
    logic [W:0]    trial;
    logic          q_bit;
    logic [W-1:0]  rem_next;
    logic [W-1:0]  quo_next;
    logic [W-1:0]  acc_next;
    logic [W-1:0]  opa_next;
    logic [W-1:0]  opb_next;
    logic          last;

    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (opa[j])
                partial = partial + (opb << j);
        end
    end

    assign mul_acc = acc + partial;

    // Restoring step: bring in the next dividend bit, subtract the divisor,
    // keep the difference only when it did not go negative.
    assign shifted  = {acc, opa[W-1]};
    assign trial    = shifted - {1'b0, opb};
    assign q_bit    = ~trial[W];
    assign rem_next = q_bit ? trial[W-1:0] : shifted[W-1:0];
    assign quo_next = {opa[W-2:0], q_bit};

    always_comb begin
        if (mode == OPC_MUL) begin
            acc_next = mul_acc;
            opa_next = opa >> MUL_BITS;
            opb_next = opb << MUL_BITS;
        end else begin
            acc_next = rem_next;
            opa_next = quo_next;
            opb_next = opb;
        end
    end

    assign last = (mode == OPC_MUL) ? (cnt == MUL_LAST) : (cnt == DIV_LAST);
    assign done = active && last;

    // A zero divisor runs the full iteration count, then reports 0.
    always_comb begin
        result = '0;
        case (mode)
            OPC_MUL: result = mul_acc;
            OPC_DIV: result = (opb == '0) ? '0 : quo_next;
            OPC_MOD: result = (opb == '0) ? '0 : rem_next;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            mode   <= OPC_SINGLE;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
        end else if (clear) begin
            active <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
        end else if (start) begin
            active <= 1'b1;
            mode   <= op;
            cnt    <= '0;
            acc    <= '0;
            if (op == OPC_MUL) begin
                opa <= b;
                opb <= a;
            end else begin
                opa <= a;
                opb <= b;
            end
        end else if (active) begin
            acc <= acc_next;
            opa <= opa_next;
            opb <= opb_next;
            if (last) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/lc4_alu_mc.sv
// Multi-cycle LC4 ALU with valid/ready handshakes on both sides.
// Single-cycle ops produce a result the cycle after acceptance; MUL, DIV
// and MOD are handed to lc4_alu_iter and report when it finishes.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | no work; ready for a request
//   MUL     | shift-add multiply iterating
//   DIV     | restoring divide (DIV or MOD) iterating
//   DONE    | o_result valid, held until the consumer takes it
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_valid / o_ready     request handshake (i_insn, i_pc, i_r1data, i_r2data)
//   i_flush               drop the operation in flight and any held result
//   o_valid / i_ready     result handshake (o_result)
//   o_busy                high while an iterative op is running
module lc4_alu_mc
    import lc4_alu_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int MUL_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [15:0]          i_insn,
    input  logic [15:0]          i_pc,
    input  logic [WORD_SIZE-1:0] i_r1data,
    input  logic [WORD_SIZE-1:0] i_r2data,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] o_result,
    output logic                 o_busy
);

    localparam int W = WORD_SIZE;

    state_t       state;
    state_t       next_state;
    state_t       launch_state;
    op_class_t    op_class;
    logic         accept;
    logic         iter_done;
    logic [W-1:0] iter_result;
    logic [W-1:0] single_result;
    logic [W-1:0] result_d;

    logic [W-1:0] pc_ext;
    logic [W-1:0] pc_next;
    logic [W-1:0] imm5;
    logic [W-1:0] imm6;
    logic [W-1:0] imm7s;
    logic [W-1:0] imm7u;
    logic [W-1:0] imm9;
    logic [W-1:0] imm11;
    logic [W-1:0] cmp_result;
    logic         cmp_lt;
    logic         cmp_eq;

    // Handshakes -----------------------------------------------------------
    // o_ready is gated by reset so every output reads 0 while held in reset.
    assign o_ready  = i_rst_n && ((state == ST_IDLE) || (state == ST_DONE && i_ready));
    assign accept   = i_valid && o_ready && !i_flush;
    assign o_valid  = (state == ST_DONE);
    assign o_busy   = (state == ST_MUL) || (state == ST_DIV);
    assign op_class = decode_class(i_insn);

    always_comb begin
        case (op_class)
            OPC_MUL:         launch_state = ST_MUL;
            OPC_DIV,
            OPC_MOD:         launch_state = ST_DIV;
            default:         launch_state = ST_DONE;
        endcase
    end

    // Immediates and PC-relative terms -------------------------------------
    assign pc_ext  = W'(i_pc);
    assign pc_next = pc_ext + W'(1);
    assign imm5    = W'($signed(i_insn[4:0]));
    assign imm6    = W'($signed(i_insn[5:0]));
    assign imm7s   = W'($signed(i_insn[6:0]));
    assign imm7u   = W'(i_insn[6:0]);
    assign imm9    = W'($signed(i_insn[8:0]));
    assign imm11   = W'($signed(i_insn[10:0]));

    always_comb begin
        cmp_lt = 1'b0;
        cmp_eq = 1'b0;
        case (i_insn[8:7])
            CMP_S: begin
                cmp_lt = $signed(i_r1data) < $signed(i_r2data);
                cmp_eq = i_r1data == i_r2data;
            end
            CMP_U: begin
                cmp_lt = i_r1data < i_r2data;
                cmp_eq = i_r1data == i_r2data;
            end
            CMP_SI: begin
                cmp_lt = $signed(i_r1data) < $signed(imm7s);
                cmp_eq = i_r1data == imm7s;
            end
            default: begin
                cmp_lt = i_r1data < imm7u;
                cmp_eq = i_r1data == imm7u;
            end
        endcase
        cmp_result = cmp_eq ? '0 : (cmp_lt ? '1 : W'(1));
    end

    // Single-cycle datapath --------------------------------------------------
    always_comb begin
        single_result = '0;
        case (i_insn[15:12])
            OP_BR: single_result = pc_next + imm9;
            OP_ARITH: begin
                if (i_insn[5])
                    single_result = i_r1data + imm5;
                else if (i_insn[5:3] == ARITH_ADD)
                    single_result = i_r1data + i_r2data;
                else if (i_insn[5:3] == ARITH_SUB)
                    single_result = i_r1data - i_r2data;
                else
                    single_result = '0;
            end
            OP_CMP: single_result = cmp_result;
            OP_JSR: begin
                if (i_insn[11])
                    single_result = (pc_ext & W'(16'h8000)) | (W'(i_insn[10:0]) << 4);
                else
                    single_result = i_r1data;
            end
            OP_LOGIC: begin
                if (i_insn[5])
                    single_result = i_r1data & imm5;
                else begin
                    case (i_insn[5:3])
                        LOGIC_AND: single_result = i_r1data & i_r2data;
                        LOGIC_NOT: single_result = ~i_r1data;
                        LOGIC_OR:  single_result = i_r1data | i_r2data;
                        LOGIC_XOR: single_result = i_r1data ^ i_r2data;
                        default:   single_result = '0;
                    endcase
                end
            end
            OP_LDR, OP_STR: single_result = i_r1data + imm6;
            // RTI's source register is R7, read through the r1 port
            OP_RTI:   single_result = i_r1data;
            OP_CONST: single_result = imm9;
            OP_SHIFT: begin
                case (i_insn[5:4])
                    SHF_SLL: single_result = i_r1data << i_insn[3:0];
                    SHF_SRA: single_result = W'($signed(i_r1data) >>> i_insn[3:0]);
                    SHF_SRL: single_result = i_r1data >> i_insn[3:0];
                    default: single_result = '0;
                endcase
            end
            OP_JMP: begin
                if (i_insn[11])
                    single_result = pc_next + imm11;
                else
                    single_result = i_r1data;
            end
            // HICONST reads its destination through the r1 port
            OP_HICONST: single_result = (i_r1data & W'(16'h00FF)) | W'({i_insn[7:0], 8'h00});
            OP_TRAP:    single_result = W'({8'h80, i_insn[7:0]});
            default:    single_result = '0;
        endcase
    end

    // Iterative datapath -----------------------------------------------------
    lc4_alu_iter #(
        .WORD_SIZE (WORD_SIZE),
        .MUL_BITS  (MUL_BITS)
    ) u_iter (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (i_flush),
        .start  (accept && (op_class != OPC_SINGLE)),
        .op     (op_class),
        .a      (i_r1data),
        .b      (i_r2data),
        .done   (iter_done),
        .result (iter_result)
    );

    // FSM ----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        result_d   = o_result;
        if (i_flush) begin
            next_state = ST_IDLE;
            result_d   = '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        next_state = launch_state;
                        if (op_class == OPC_SINGLE)
                            result_d = single_result;
                    end else if (state == ST_DONE && i_ready) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (iter_done) begin
                        next_state = ST_DONE;
                        result_d   = iter_result;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            o_result <= '0;
        end else begin
            state    <= next_state;
            o_result <= result_d;
        end
    end

endmodule

// File: tb/tb_lc4_alu_mc.sv
module tb_lc4_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [15:0] i_insn;
    logic [15:0] i_pc;
    logic [15:0] i_r1data;
    logic [15:0] i_r2data;
    logic        i_flush;
    logic        i_ready;

    logic        o_ready,  o_valid,  o_busy;
    logic [15:0] o_result;
    logic        o_ready4, o_valid4, o_busy4;
    logic [15:0] o_result4;

    int tests = 0;
    int fails = 0;
    int lat, lat4, cnt;

    always #5 clk = ~clk;

    lc4_alu_mc #(.WORD_SIZE(16), .MUL_BITS(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_insn(i_insn), .i_pc(i_pc), .i_r1data(i_r1data), .i_r2data(i_r2data),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_busy(o_busy)
    );

    lc4_alu_mc #(.WORD_SIZE(16), .MUL_BITS(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready4),
        .i_insn(i_insn), .i_pc(i_pc), .i_r1data(i_r1data), .i_r2data(i_r2data),
        .i_flush(i_flush), .o_valid(o_valid4), .i_ready(i_ready),
        .o_result(o_result4), .o_busy(o_busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] insn, input logic [15:0] pc,
                         input logic [15:0] r1, input logic [15:0] r2);
        i_valid  = 1'b1;
        i_insn   = insn;
        i_pc     = pc;
        i_r1data = r1;
        i_r2data = r2;
        step();
        i_valid  = 1'b0;
    endtask

    // First cycle (1 = cycle after acceptance) each instance shows o_valid.
    task automatic wait_valid(output int l, output int l4);
        l  = 0;
        l4 = 0;
        for (int k = 1; k <= 40; k++) begin
            if (o_valid && l == 0)   l  = k;
            if (o_valid4 && l4 == 0) l4 = k;
            if (l != 0 && l4 != 0) break;
            step();
        end
    endtask

    logic [15:0] v_insn [14];
    logic [15:0] v_pc   [14];
    logic [15:0] v_r1   [14];
    logic [15:0] v_r2   [14];
    logic [15:0] v_exp  [14];

    initial begin
        //          insn      pc        r1        r2        expected
        v_insn = '{16'h1010, 16'h103F, 16'h2080, 16'h217F, 16'h91FF, 16'hD1AB, 16'hA014,
                   16'hA024, 16'h0FFE, 16'h4801, 16'hF0AB, 16'h5018, 16'h603F, 16'hCFFF};
        v_pc   = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                   16'h0000, 16'h0010, 16'h8123, 16'h0000, 16'h0000, 16'h0000, 16'h0020};
        v_r1   = '{16'h0003, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h1234, 16'h8000,
                   16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 16'h1000, 16'h0000};
        v_r2   = '{16'h0005, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 16'h0000, 16'h0000};
        v_exp  = '{16'hFFFE, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 16'hAB34, 16'hF800,
                   16'h0800, 16'h000F, 16'h8010, 16'h80AB, 16'h0FF0, 16'h0FFF, 16'h0020};

        rst_n = 1'b0; i_valid = 1'b0; i_insn = '0; i_pc = '0;
        i_r1data = '0; i_r2data = '0; i_flush = 1'b0; i_ready = 1'b1;

        // Reset values
        step(); step();
        check("rst_valid",  o_valid,  0);
        check("rst_result", o_result, 0);
        check("rst_busy",   o_busy,   0);
        check("rst_ready",  o_ready,  0);
        rst_n = 1'b1;
        step();
        check("idle_ready", o_ready, 1);

        // ADD 5+3, latency 1
        issue(16'h1000, 16'h0000, 16'h0005, 16'h0003);
        wait_valid(lat, lat4);
        check("add_lat", lat, 1);
        check("add_res", o_result, 16'h0008);
        step();
        check("add_consumed", o_valid, 0);

        // Single-cycle op table
        for (int i = 0; i < 14; i++) begin
            issue(v_insn[i], v_pc[i], v_r1[i], v_r2[i]);
            check($sformatf("single_%0d_valid", i), o_valid, 1);
            check($sformatf("single_%0d_res", i), o_result, v_exp[i]);
            step();
        end

        // MUL 0x0123*0x0045, held in DONE so both instances can be timed
        i_ready = 1'b0;
        issue(16'h1008, 16'h0000, 16'h0123, 16'h0045);
        check("mul_busy", o_busy, 1);
        check("mul_not_ready", o_ready, 0);
        wait_valid(lat, lat4);
        check("mul1_lat", lat, 17);
        check("mul4_lat", lat4, 5);
        check("mul1_res", o_result, 16'h4E6F);
        check("mul4_res", o_result4, 16'h4E6F);
        i_ready = 1'b1;
        step();
        check("mul_consumed", o_valid, 0);

        // DIV / MOD, including zero divisor
        issue(16'h1018, 16'h0000, 16'h0064, 16'h0007);
        wait_valid(lat, lat4);
        check("div_lat", lat, 17);
        check("div_res", o_result, 16'h000E);
        step();
        issue(16'hA030, 16'h0000, 16'h0064, 16'h0007);
        wait_valid(lat, lat4);
        check("mod_lat", lat, 17);
        check("mod_res", o_result, 16'h0002);
        step();
        issue(16'h1018, 16'h0000, 16'h0064, 16'h0000);
        wait_valid(lat, lat4);
        check("div0_lat", lat, 17);
        check("div0_res", o_result, 16'h0000);
        step();
        issue(16'hA030, 16'h0000, 16'h0064, 16'h0000);
        wait_valid(lat, lat4);
        check("mod0_lat", lat, 17);
        check("mod0_res", o_result, 16'h0000);
        step();

        // Backpressure: result held 5 cycles, then back-to-back issue
        i_ready = 1'b0;
        issue(16'h1010, 16'h0000, 16'h0010, 16'h0003);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", o_valid, 1);
            check("bp_res",   o_result, 16'h000D);
            check("bp_ready", o_ready, 0);
            step();
        end
        i_ready  = 1'b1;
        i_valid  = 1'b1;
        i_insn   = 16'h1000;
        i_r1data = 16'h0100;
        i_r2data = 16'h0001;
        #1;
        check("b2b_ready", o_ready, 1);
        step();
        i_valid = 1'b0;
        check("b2b_valid", o_valid, 1);
        check("b2b_res",   o_result, 16'h0101);
        step();

        // A request during a flush in IDLE is not taken
        i_flush  = 1'b1;
        i_valid  = 1'b1;
        i_insn   = 16'h1000;
        i_r1data = 16'h0009;
        i_r2data = 16'h0009;
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush_idle_valid", o_valid, 0);

        // Flush at cycle 8 of a DIV
        issue(16'h1018, 16'h0000, 16'h0064, 16'h0007);
        for (int i = 0; i < 7; i++) step();
        check("flush_div_busy_before", o_busy, 1);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_insn  = 16'h1000;
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush_busy",  o_busy,  0);
        check("flush_ready", o_ready, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_valid) cnt++;
            step();
        end
        check("flush_no_valid", cnt, 0);
        issue(16'h1000, 16'h0000, 16'h0002, 16'h0002);
        check("post_flush_valid", o_valid, 1);
        check("post_flush_res",   o_result, 16'h0004);
        step();

        // Reset in the middle of a MUL
        issue(16'h1008, 16'h0000, 16'h0003, 16'h0004);
        for (int i = 0; i < 4; i++) step();
        check("rmul_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check("rmul_valid",  o_valid,  0);
        check("rmul_result", o_result, 0);
        check("rmul_busy0",  o_busy,   0);
        check("rmul_ready",  o_ready,  0);
        step(); step();
        rst_n = 1'b1;
        #2;
        check("rmul_ready_rel", o_ready, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_valid || o_busy) cnt++;
            step();
        end
        check("rmul_abandoned", cnt, 0);
        issue(16'h2000, 16'h0000, 16'hFFFF, 16'h0001);
        check("cmp_valid", o_valid, 1);
        check("cmp_res",   o_result, 16'hFFFF);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
